// File: rtl/inst_buffer.sv
// Instruction buffer: a circular FIFO of raw RV32/RVV words with a show-ahead
// decoder on the head entry and in-order issue gated by scoreboard vacancy.
module inst_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        ib_vacant_ALU,
  input  logic        ib_vacant_LS,
  output logic        ib_valid,
  output logic [6:0]  ib_opt,
  output logic [2:0]  ib_funct3,
  output logic [5:0]  ib_funct6,
  output logic [5:0]  ib_rs1,
  output logic [5:0]  ib_rs2,
  output logic [5:0]  ib_rd,
  output logic [31:0] ib_imm,
  output logic        illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_VA = 7'b1010111;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_VL = 7'b0000111;
  localparam logic [6:0] OP_VS = 7'b0100111;

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   count_r;

  logic [31:0] head_inst_s;
  logic        not_empty_s;
  logic        is_alu_s;
  logic        is_ls_s;
  logic        issue_s;
  logic        drop_s;
  logic        push_s;
  logic        pop_s;

  assign not_empty_s = (count_r != {(AW + 1){1'b0}});
  assign if_ready    = (count_r < DEPTH_C);
  assign push_s      = if_valid && if_ready;

  // Head word, forced to zero when empty so the decoded fields never carry X
  always_comb begin
    head_inst_s = 32'd0;
    if (not_empty_s) begin
      head_inst_s = mem_r[head_r];
    end else begin
      head_inst_s = 32'd0;
    end
  end

  // Issue class of the head opcode
  always_comb begin
    is_alu_s = 1'b0;
    is_ls_s  = 1'b0;
    case (head_inst_s[6:0])
      OP_R, OP_I, OP_B, OP_VA:   is_alu_s = 1'b1;
      OP_L, OP_S, OP_VL, OP_VS:  is_ls_s  = 1'b1;
      default: begin
        is_alu_s = 1'b0;
        is_ls_s  = 1'b0;
      end
    endcase
  end

  assign issue_s  = not_empty_s && ((is_alu_s && ib_vacant_ALU) || (is_ls_s && ib_vacant_LS));
  assign drop_s   = not_empty_s && !is_alu_s && !is_ls_s;
  assign pop_s    = issue_s || drop_s;
  assign ib_valid = issue_s;
  assign illegal  = drop_s;

  assign ib_opt    = head_inst_s[6:0];
  assign ib_funct3 = head_inst_s[14:12];
  assign ib_funct6 = head_inst_s[31:26];

  // Operand/immediate decode; scalar indices use a 0 MSB so x0 reads as 0
  always_comb begin
    ib_rs1 = 6'd0;
    ib_rs2 = 6'd0;
    ib_rd  = 6'd0;
    ib_imm = 32'd0;
    case (head_inst_s[6:0])
      OP_R: begin
        ib_rs1 = {1'b0, head_inst_s[19:15]};
        ib_rs2 = {1'b0, head_inst_s[24:20]};
        ib_rd  = {1'b0, head_inst_s[11:7]};
      end
      OP_I, OP_L: begin
        ib_rs1 = {1'b0, head_inst_s[19:15]};
        ib_rd  = {1'b0, head_inst_s[11:7]};
        ib_imm = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
      end
      OP_S: begin
        ib_rs1 = {1'b0, head_inst_s[19:15]};
        ib_rs2 = {1'b0, head_inst_s[24:20]};
        ib_imm = {{20{head_inst_s[31]}}, head_inst_s[31:25], head_inst_s[11:7]};
      end
      OP_B: begin
        ib_rs1 = {1'b0, head_inst_s[19:15]};
        ib_rs2 = {1'b0, head_inst_s[24:20]};
        ib_imm = {{20{head_inst_s[31]}}, head_inst_s[7], head_inst_s[30:25],
                  head_inst_s[11:8], 1'b0};
      end
      OP_VL: begin
        ib_rs1 = {1'b0, head_inst_s[19:15]};
        ib_rd  = {1'b1, head_inst_s[11:7]};
      end
      OP_VS: begin
        ib_rs1 = {1'b0, head_inst_s[19:15]};
        ib_rs2 = {1'b1, head_inst_s[11:7]};
      end
      OP_VA: begin
        ib_rd  = {1'b1, head_inst_s[11:7]};
        ib_rs2 = {1'b1, head_inst_s[24:20]};
        case (head_inst_s[14:12])
          3'b000:  ib_rs1 = {1'b1, head_inst_s[19:15]};
          3'b100:  ib_rs1 = {1'b0, head_inst_s[19:15]};
          3'b011:  ib_imm = {{27{head_inst_s[19]}}, head_inst_s[19:15]};
          default: begin
            ib_rs1 = 6'd0;
            ib_imm = 32'd0;
          end
        endcase
      end
      default: begin
        ib_rs1 = 6'd0;
        ib_rs2 = 6'd0;
        ib_rd  = 6'd0;
        ib_imm = 32'd0;
      end
    endcase
  end

  // Storage array; stale entries are ignored through count_r, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[tail_r] <= if_inst;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: a negedge scoreboard tracks accepted words and checks
// every issue/discard, while scenario tasks add targeted inline checks.
module tb_inst_buffer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [6:0]  opt;
    logic [2:0]  f3;
    logic [5:0]  f6;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] imm;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = 32'd0;
  logic        if_ready;
  logic        vac_alu = 1'b0;
  logic        vac_ls = 1'b0;
  logic        ib_valid;
  logic [6:0]  ib_opt;
  logic [2:0]  ib_funct3;
  logic [5:0]  ib_funct6;
  logic [5:0]  ib_rs1;
  logic [5:0]  ib_rs2;
  logic [5:0]  ib_rd;
  logic [31:0] ib_imm;
  logic        illegal;
  fields_t     dut_f;

  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [31:0] sbq[$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_ready(if_ready),
    .ib_vacant_ALU(vac_alu), .ib_vacant_LS(vac_ls), .ib_valid(ib_valid),
    .ib_opt(ib_opt), .ib_funct3(ib_funct3), .ib_funct6(ib_funct6),
    .ib_rs1(ib_rs1), .ib_rs2(ib_rs2), .ib_rd(ib_rd), .ib_imm(ib_imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign dut_f = {ib_opt, ib_funct3, ib_funct6, ib_rs1, ib_rs2, ib_rd, ib_imm};

  // 1 = ALU, 2 = load/store, 0 = unknown
  function automatic int cls(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h63, 7'h57: return 1;
      7'h03, 7'h23, 7'h07, 7'h27: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic fields_t model(input logic [31:0] w);
    fields_t f;
    logic [5:0] s1, s2, d, v2, vd;
    s1 = {1'b0, w[19:15]};
    s2 = {1'b0, w[24:20]};
    d  = {1'b0, w[11:7]};
    v2 = 6'd32 + {1'b0, w[24:20]};
    vd = 6'd32 + {1'b0, w[11:7]};
    f = '0;
    f.opt = w[6:0];
    f.f3  = w[14:12];
    f.f6  = w[31:26];
    case (w[6:0])
      7'h33: begin f.rs1 = s1; f.rs2 = s2; f.rd = d; end
      7'h13, 7'h03: begin f.rs1 = s1; f.rd = d; f.imm = 32'($signed(w[31:20])); end
      7'h23: begin f.rs1 = s1; f.rs2 = s2; f.imm = 32'($signed({w[31:25], w[11:7]})); end
      7'h63: begin f.rs1 = s1; f.rs2 = s2;
                   f.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
      7'h07: begin f.rs1 = s1; f.rd = vd; end
      7'h27: begin f.rs1 = s1; f.rs2 = vd; end
      7'h57: begin
        f.rd = vd;
        f.rs2 = v2;
        if (w[14:12] == 3'b000) f.rs1 = 6'd32 + {1'b0, w[19:15]};
        else if (w[14:12] == 3'b100) f.rs1 = s1;
        else if (w[14:12] == 3'b011) f.imm = 32'($signed(w[19:15]));
      end
      default: f = f;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] rand_word(input bit allow_bad);
    logic [6:0] ops [9];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h63, 7'h57, 7'h03, 7'h23, 7'h07, 7'h27, 7'h7F};
    w = $urandom;
    w[6:0] = ops[allow_bad ? $urandom_range(0, 8) : $urandom_range(0, 7)];
    return w;
  endfunction

  // Scoreboard: compare head behaviour against the queued model, then update it
  always @(negedge clk) begin
    logic [31:0] h;
    bit have, full, exp_v, exp_ill;
    fields_t ef;
    if (mon_en) begin
      have = (sbq.size() > 0);
      full = (sbq.size() >= DEPTH);
      h = have ? sbq[0] : 32'd0;
      exp_v = have && ((cls(h) == 1 && vac_alu) || (cls(h) == 2 && vac_ls));
      exp_ill = have && (cls(h) == 0);
      n_checks++;
      if (ib_valid !== exp_v || illegal !== exp_ill || if_ready !== !full)
        $display("FAIL sb_ctrl t=%0t valid/illegal/ready got %b%b%b want %b%b%b",
                 $time, ib_valid, illegal, if_ready, exp_v, exp_ill, !full);
      else n_pass++;
      if (exp_v) begin
        ef = model(h);
        n_checks++;
        if (dut_f !== ef)
          $display("FAIL sb_fields t=%0t inst=%h got %h want %h", $time, h, dut_f, ef);
        else n_pass++;
      end
      if (rst) sbq.delete();
      else begin
        if (exp_v || exp_ill) void'(sbq.pop_front());
        if (if_valid && !full) sbq.push_back(if_inst);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if_ready !== 1'b1 || ib_valid !== 1'b0 || illegal !== 1'b0)
      $display("FAIL reset ready/valid/illegal got %b%b%b want 100", if_ready, ib_valid, illegal);
    else n_pass++;
    tick();
  endtask

  task automatic test_single_add;
    vac_alu = 1'b1;
    vac_ls = 1'b0;
    if_valid = 1'b1;
    if_inst = 32'h002081B3;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ib_valid !== 1'b1 || ib_opt !== 7'h33 || ib_rs1 !== 6'd1 || ib_rs2 !== 6'd2 ||
        ib_rd !== 6'd3 || ib_imm !== 32'd0)
      $display("FAIL add_issue got v=%b opt=%h rs1=%0d rs2=%0d rd=%0d imm=%h want 1 33 1 2 3 0",
               ib_valid, ib_opt, ib_rs1, ib_rs2, ib_rd, ib_imm);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (ib_valid !== 1'b0 || if_ready !== 1'b1)
      $display("FAIL add_empty got valid=%b ready=%b want 0 1", ib_valid, if_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_fill;
    logic [31:0] w [9];
    w = '{32'h002081B3, 32'hFFF00293, 32'h00812303, 32'hFE70AE23, 32'hFE208CE3,
          32'h02056207, 32'h020562A7, 32'h022180D7, 32'h0220C0D7};
    vac_alu = 1'b0;
    vac_ls = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if_valid = 1'b1;
      if_inst = w[i];
      tick();
    end
    if_inst = w[8];
    @(negedge clk);
    n_checks++;
    if (if_ready !== 1'b0)
      $display("FAIL full_ready got %b want 0", if_ready);
    else n_pass++;
    tick();
    if_valid = 1'b0;
    vac_alu = 1'b1;
    vac_ls = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_checks++;
      if (ib_valid !== 1'b1 || ib_opt !== w[i][6:0] || ib_rd !== model(w[i]).rd)
        $display("FAIL drain_order[%0d] got v=%b opt=%h rd=%0d want 1 %h %0d",
                 i, ib_valid, ib_opt, ib_rd, w[i][6:0], model(w[i]).rd);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (ib_valid !== 1'b0)
      $display("FAIL ninth_dropped got valid=%b want 0", ib_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_ls_block;
    vac_alu = 1'b1;
    vac_ls = 1'b0;
    if_valid = 1'b1;
    if_inst = 32'hFE70AE23;
    tick();
    if_inst = 32'h002081B3;
    tick();
    if_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (ib_valid !== 1'b0 || ib_opt !== 7'h23)
        $display("FAIL ls_block[%0d] got valid=%b opt=%h want 0 23", i, ib_valid, ib_opt);
      else n_pass++;
      tick();
    end
    vac_ls = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ib_valid !== 1'b1 || ib_opt !== 7'h23)
      $display("FAIL ls_release got valid=%b opt=%h want 1 23", ib_valid, ib_opt);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (ib_valid !== 1'b1 || ib_opt !== 7'h33)
      $display("FAIL ls_then_add got valid=%b opt=%h want 1 33", ib_valid, ib_opt);
    else n_pass++;
    tick();
  endtask

  task automatic test_illegal;
    vac_alu = 1'b1;
    vac_ls = 1'b1;
    if_valid = 1'b1;
    if_inst = 32'h0000007F;
    tick();
    if_inst = 32'h002081B3;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (illegal !== 1'b0 || ib_valid !== 1'b1 || ib_opt !== 7'h33)
      $display("FAIL after_illegal got illegal=%b valid=%b opt=%h want 0 1 33",
               illegal, ib_valid, ib_opt);
    else n_pass++;
    tick();
  endtask

  task automatic test_illegal_pulse;
    vac_alu = 1'b1;
    if_valid = 1'b1;
    if_inst = 32'h0000007F;
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (illegal !== 1'b1 || ib_valid !== 1'b0)
      $display("FAIL illegal_pulse got illegal=%b valid=%b want 1 0", illegal, ib_valid);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (illegal !== 1'b0)
      $display("FAIL illegal_once got %b want 0", illegal);
    else n_pass++;
    tick();
  endtask

  task automatic test_va;
    vac_alu = 1'b1;
    if_valid = 1'b1;
    if_inst = 32'h022F30D7;
    tick();
    if_inst = 32'h022120D7;
    @(negedge clk);
    n_checks++;
    if (ib_valid !== 1'b1 || ib_rs1 !== 6'd0 || ib_imm !== 32'hFFFFFFFE ||
        ib_rd !== 6'd33 || ib_rs2 !== 6'd34)
      $display("FAIL va_imm got v=%b rs1=%0d imm=%h rd=%0d rs2=%0d want 1 0 fffffffe 33 34",
               ib_valid, ib_rs1, ib_imm, ib_rd, ib_rs2);
    else n_pass++;
    tick();
    if_inst = 32'h022180D7;
    tick();
    if_inst = 32'h0220C0D7;
    tick();
    if_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    vac_alu = 1'b0;
    vac_ls = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_valid = 1'b1;
      if_inst = rand_word(1'b0);
      tick();
    end
    rst = 1'b1;
    if_inst = 32'h002081B3;
    tick();
    rst = 1'b0;
    if_valid = 1'b0;
    vac_alu = 1'b1;
    vac_ls = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if_ready !== 1'b1 || ib_valid !== 1'b0 || illegal !== 1'b0)
      $display("FAIL mid_reset got ready/valid/illegal %b%b%b want 100", if_ready, ib_valid, illegal);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back;
    vac_alu = 1'b1;
    vac_ls = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if_valid = (i < 20);
      if_inst = rand_word(1'b0);
      if (i > 0) begin
        @(negedge clk);
        n_checks++;
        if (ib_valid !== 1'b1 || if_ready !== 1'b1)
          $display("FAIL b2b[%0d] got valid=%b ready=%b want 1 1", i, ib_valid, if_ready);
        else n_pass++;
      end
      tick();
    end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_inst = rand_word(1'b1);
      vac_alu = ($urandom_range(0, 2) != 0);
      vac_ls = ($urandom_range(0, 2) != 0);
      tick();
    end
    if_valid = 1'b0;
    vac_alu = 1'b1;
    vac_ls = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    @(negedge clk);
    n_checks++;
    if (ib_valid !== 1'b0 || sbq.size() != 0)
      $display("FAIL random_drain got valid=%b pending=%0d want 0 0", ib_valid, sbq.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fill();
    test_ls_block();
    test_illegal();
    test_illegal_pulse();
    test_va();
    test_reset_mid();
    test_back_to_back();
    test_random();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
